cpu_pc_ctrl: RTL and testbench
==============================

# cpu_pc_ctrl

Program-flow controller for the one-cycle CPU's program counter. Each cycle it decodes the current flow-control opcode and drives the counter's load strobe and load address. It handles unconditional and zero-flag-conditional jumps, subroutine call/return through a small return-address stack, and a halt/resume state. It sits between the instruction decoder and the program counter: the PC output feeds back into PC, and LD/ADDR drive the counter's load inputs.

## Interface
- WIDTH, 8, address width; matches the program counter width
- DEPTH, 4, return-stack entries (power of two, ≥2)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- PC  in  WIDTH  current program counter value
- OP  in  3  flow opcode: 000 NOP, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 HALT, 111 reserved (decoded as NOP)
- TARGET  in  WIDTH  jump/call destination
- ZF  in  1  ALU zero flag, valid in the same cycle as OP
- RESUME  in  1  leave halt; level-sampled
- LD  out  1  program-counter load strobe (combinational)
- ADDR  out  WIDTH  program-counter load address (combinational)
- HALTED  out  1  registered; 1 while in HALT state
- STK_ERR  out  1  registered, sticky; stack overflow or underflow has occurred
- SP  out  clog2(DEPTH)+1  registered stack occupancy, 0..DEPTH

## Operation
- States: RUN, HALT. Reset → RUN. Reset values: HALTED=0, STK_ERR=0, SP=0, stack contents=0. While RST is low: LD=0, ADDR=0.
- RUN decode (combinational LD/ADDR; register updates on the next rising CLK):
  - NOP/111: LD=0, ADDR=0.
  - JMP: LD=1, ADDR=TARGET.
  - JZ: LD=ZF, ADDR=TARGET. JNZ: LD=~ZF, ADDR=TARGET. When not taken, ADDR=0.
  - CALL, SP<DEPTH: LD=1, ADDR=TARGET; push PC+1 (mod 2^WIDTH, so PC=2^WIDTH−1 pushes 0); SP+1.
  - CALL, SP=DEPTH (full): LD=0, no push, SP unchanged; STK_ERR←1.
  - RET, SP>0: LD=1, ADDR=top entry; pop; SP−1.
  - RET, SP=0 (empty): LD=0, SP unchanged; STK_ERR←1.
  - HALT: LD=1, ADDR=PC, so the counter stays put; state→HALT.
- HALT state: OP, TARGET and ZF are ignored, and the stack is frozen.
  - RESUME=0: LD=1, ADDR=PC.
  - RESUME=1: LD=1, ADDR=PC+1 (mod 2^WIDTH); state→RUN.
- HALTED=1 exactly while the state is HALT.
- STK_ERR is cleared only by reset.
- Stack is LIFO, with entries indexed by SP−1.

## Timing
- LD/ADDR have zero latency: they are combinational from OP, ZF, TARGET, PC, state and stack top, and the program counter captures them on the same edge.
- SP, stack, HALTED and STK_ERR update on the rising edge that ends the instruction cycle.
- A RET in the cycle immediately after a CALL returns the address pushed by that CALL, with no bypass hazard.
- HALTED rises on the edge after the HALT opcode and falls on the edge after the RESUME=1 cycle.
- RESUME asserted while in RUN has no effect.
- Asynchronous reset in mid-halt or mid-stack: all registered state clears immediately, and LD=0 while RST is low.

## Configuration
- CPU_PC_CTRL_STACK_EN defined: return stack, SP and STK_ERR behave as described above.
- CPU_PC_CTRL_STACK_EN undefined: no stack storage is built.
  - CALL decodes as JMP (LD=1, ADDR=TARGET).
  - RET decodes as NOP.
  - SP is tied to 0 and STK_ERR is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset: RST=0 → LD=0, ADDR=0, HALTED=0, STK_ERR=0, SP=0. Release, OP=JMP TARGET=0x40 → LD=1, ADDR=0x40.
- Conditional: OP=JZ TARGET=0x10 ZF=1 → LD=1, ADDR=0x10. ZF=0 → LD=0. OP=JNZ ZF=0 → LD=1.
- Call/return: PC=0x05 CALL 0x80 → ADDR=0x80, SP=1. Next PC=0x80 RET → LD=1, ADDR=0x06, SP=0. PC=0xFF CALL then RET → ADDR=0x00.
- Stack errors: 4 CALLs → SP=4. 5th CALL → LD=0, SP=4, STK_ERR=1. 4 RETs then a 5th RET → LD=0, SP=0, STK_ERR stays 1.
- Halt: PC=0x22 OP=HALT → LD=1, ADDR=0x22, then HALTED=1. OP=JMP while halted → ignored (ADDR=0x22). RESUME=1 → ADDR=0x23, then HALTED=0.
- Macro off: CALL 0x30 → LD=1, ADDR=0x30, SP=0. RET → LD=0. STK_ERR stays 0.

Source files
------------

// File: rtl/cpu_pc_ctrl.sv
// cpu_pc_ctrl -- program-flow controller for the one-cycle CPU's program counter.
//
// Each cycle the current flow opcode is decoded into a load strobe (LD) and a
// load address (ADDR) for the program counter. The design supports
// unconditional and zero-flag conditional jumps, CALL/RET through a small
// return-address stack, and a HALT state that is left with RESUME.
//
// Optional feature macro: CPU_PC_CTRL_STACK_EN
//   defined   : return stack, SP and STK_ERR are built.
//   undefined : no stack storage; CALL acts as JMP, RET acts as NOP,
//               SP and STK_ERR are tied to 0.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous active-low reset
//   PC       in   current program counter value
//   OP       in   flow opcode (NOP, JMP, JZ, JNZ, CALL, RET, HALT, reserved)
//   TARGET   in   jump/call destination
//   ZF       in   ALU zero flag, valid with OP
//   RESUME   in   leave HALT (level-sampled)
//   LD       out  program-counter load strobe (combinational)
//   ADDR     out  program-counter load address (combinational)
//   HALTED   out  registered, 1 while in the HALT state
//   STK_ERR  out  registered, sticky stack overflow/underflow flag
//   SP       out  registered stack occupancy, 0..DEPTH

module cpu_pc_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         PC,
  input  logic [2:0]               OP,
  input  logic [WIDTH-1:0]         TARGET,
  input  logic                     ZF,
  input  logic                     RESUME,
  output logic                     LD,
  output logic [WIDTH-1:0]         ADDR,
  output logic                     HALTED,
  output logic                     STK_ERR,
  output logic [$clog2(DEPTH):0]   SP
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             ld_c;
  logic [WIDTH-1:0] addr_c;
  logic [WIDTH-1:0] pc_inc;

  // Wraps naturally at 2^WIDTH, so PC = all-ones yields 0.
  assign pc_inc = PC + WIDTH'(1);

`ifdef CPU_PC_CTRL_STACK_EN
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [SPW-1:0]   sp_m1;
  logic [WIDTH-1:0] stk_top;

  // Top of stack lives at SP-1. The value is only used when SP > 0.
  assign sp_m1   = sp_q - SPW'(1);
  assign stk_top = stk_q[sp_m1[AW-1:0]];
`endif

  always_comb begin
    ld_c    = 1'b0;
    addr_c  = '0;
    state_d = state_q;
`ifdef CPU_PC_CTRL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    stk_d   = stk_q;
`endif
    if (state_q == ST_HALT) begin
      // Opcode, target and flag are ignored; the counter is held or stepped.
      ld_c = 1'b1;
      if (RESUME) begin
        addr_c  = pc_inc;
        state_d = ST_RUN;
      end else begin
        addr_c  = PC;
      end
    end else begin
      case (OP)
        OP_JMP: begin
          ld_c   = 1'b1;
          addr_c = TARGET;
        end
        OP_JZ: begin
          ld_c   = ZF;
          addr_c = ZF ? TARGET : '0;
        end
        OP_JNZ: begin
          ld_c   = ~ZF;
          addr_c = ZF ? '0 : TARGET;
        end
        OP_CALL: begin
`ifdef CPU_PC_CTRL_STACK_EN
          if (sp_q < SPW'(DEPTH)) begin
            ld_c                 = 1'b1;
            addr_c               = TARGET;
            stk_d[sp_q[AW-1:0]]  = pc_inc;
            sp_d                 = sp_q + SPW'(1);
          end else begin
            err_d = 1'b1;
          end
`else
          ld_c   = 1'b1;
          addr_c = TARGET;
`endif
        end
        OP_RET: begin
`ifdef CPU_PC_CTRL_STACK_EN
          if (sp_q != '0) begin
            ld_c   = 1'b1;
            addr_c = stk_top;
            sp_d   = sp_m1;
          end else begin
            err_d = 1'b1;
          end
`endif
        end
        OP_HALT: begin
          // Reload the current PC so the counter holds still.
          ld_c    = 1'b1;
          addr_c  = PC;
          state_d = ST_HALT;
        end
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CPU_PC_CTRL_STACK_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      stk_q <= stk_d;
    end
  end

  assign SP      = sp_q;
  assign STK_ERR = err_q;
`else
  assign SP      = '0;
  assign STK_ERR = 1'b0;
`endif

  // The load outputs are forced quiet while reset is held, independent of inputs.
  assign LD     = RST & ld_c;
  assign ADDR   = RST ? addr_c : '0;
  assign HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// Scoreboard bench for cpu_pc_ctrl: the stimulus process drives one
// instruction per cycle and pushes the reference model's expected outputs;
// a monitor pops and compares each cycle, away from the clock edge.
`timescale 1ns/1ps

module tb_cpu_pc_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef CPU_PC_CTRL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                         CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSV = 3'd7;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] PC = '0;
  logic [2:0]       OP = '0;
  logic [WIDTH-1:0] TARGET = '0;
  logic             ZF = 1'b0;
  logic             RESUME = 1'b0;
  logic             LD;
  logic [WIDTH-1:0] ADDR;
  logic             HALTED;
  logic             STK_ERR;
  logic [2:0]       SP;

  cpu_pc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .OP(OP), .TARGET(TARGET), .ZF(ZF),
    .RESUME(RESUME), .LD(LD), .ADDR(ADDR), .HALTED(HALTED),
    .STK_ERR(STK_ERR), .SP(SP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] addr;
    logic             halted;
    logic             err;
    int               sp;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: halt flag, sticky error, return addresses.
  bit               m_halted = 1'b0;
  bit               m_err    = 1'b0;
  logic [WIDTH-1:0] m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One instruction cycle: drive inputs, record expectation, advance the model.
  task automatic step(input logic rst, input logic [2:0] op, input logic [WIDTH-1:0] tgt,
                      input logic [WIDTH-1:0] pc, input logic zf, input logic res);
    exp_t e;
    @(negedge CLK);
    RST = rst; OP = op; TARGET = tgt; PC = pc; ZF = zf; RESUME = res;
    e.ld = 1'b0; e.addr = '0;
    if (!rst) begin
      m_halted = 1'b0; m_err = 1'b0; m_stk.delete();
      e.halted = 1'b0; e.err = 1'b0; e.sp = 0;
      exp_q.push_back(e);
      return;
    end
    e.halted = m_halted;
    e.err    = m_err;
    e.sp     = m_stk.size();
    if (m_halted) begin
      e.ld   = 1'b1;
      e.addr = res ? pc + 8'd1 : pc;
      if (res) m_halted = 1'b0;
    end else begin
      case (op)
        JMP:  begin e.ld = 1'b1; e.addr = tgt; end
        JZ:   if (zf)  begin e.ld = 1'b1; e.addr = tgt; end
        JNZ:  if (!zf) begin e.ld = 1'b1; e.addr = tgt; end
        CALL: begin
          if (!STK) begin
            e.ld = 1'b1; e.addr = tgt;
          end else if (m_stk.size() < DEPTH) begin
            e.ld = 1'b1; e.addr = tgt;
            m_stk.push_back(pc + 8'd1);
          end else begin
            m_err = 1'b1;
          end
        end
        RET: begin
          if (STK) begin
            if (m_stk.size() > 0) begin
              e.ld = 1'b1; e.addr = m_stk.pop_back();
            end else begin
              m_err = 1'b1;
            end
          end
        end
        HALT: begin e.ld = 1'b1; e.addr = pc; m_halted = 1'b1; end
        default: ;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare 2 ns after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("LD",      32'(LD),      32'(e.ld));
        chk("ADDR",    32'(ADDR),    32'(e.addr));
        chk("HALTED",  32'(HALTED),  32'(e.halted));
        chk("STK_ERR", 32'(STK_ERR), 32'(e.err));
        chk("SP",      32'(SP),      32'(e.sp));
      end
    end
  end

  initial begin
    // Reset, then basic jumps.
    step(1'b0, JMP, 8'h40, 8'h00, 1'b0, 1'b0);
    step(1'b0, CALL, 8'h12, 8'h33, 1'b1, 1'b1);
    step(1'b1, JMP, 8'h40, 8'h00, 1'b0, 1'b0);
    step(1'b1, JZ,  8'h10, 8'h01, 1'b1, 1'b0);
    step(1'b1, JZ,  8'h10, 8'h02, 1'b0, 1'b0);
    step(1'b1, JNZ, 8'h10, 8'h03, 1'b0, 1'b0);
    step(1'b1, JNZ, 8'h10, 8'h04, 1'b1, 1'b0);
    step(1'b1, RSV, 8'h55, 8'h05, 1'b0, 1'b1);
    // Call/return including PC wrap.
    step(1'b1, CALL, 8'h80, 8'h05, 1'b0, 1'b0);
    step(1'b1, RET,  8'h00, 8'h80, 1'b0, 1'b0);
    step(1'b1, CALL, 8'h90, 8'hFF, 1'b0, 1'b0);
    step(1'b1, RET,  8'h00, 8'h90, 1'b0, 1'b0);
    // Overflow then underflow.
    for (int i = 0; i < 5; i++) step(1'b1, CALL, 8'(8'hA0 + i), 8'(8'h10 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, RET, 8'h00, 8'hEE, 1'b0, 1'b0);
    step(1'b1, NOP, 8'h00, 8'h00, 1'b0, 1'b0);
    // Halt, ignored jump, resume.
    step(1'b1, HALT, 8'h77, 8'h22, 1'b0, 1'b0);
    step(1'b1, JMP,  8'h40, 8'h22, 1'b1, 1'b0);
    step(1'b1, CALL, 8'h40, 8'h22, 1'b0, 1'b1);
    step(1'b1, NOP,  8'h00, 8'h23, 1'b0, 1'b0);
    step(1'b1, HALT, 8'h00, 8'hFF, 1'b0, 1'b0);
    step(1'b1, NOP,  8'h00, 8'hFF, 1'b0, 1'b1);
    // Reset in mid-halt and mid-stack.
    step(1'b1, CALL, 8'h31, 8'h08, 1'b0, 1'b0);
    step(1'b1, HALT, 8'h00, 8'h31, 1'b0, 1'b0);
    step(1'b0, JMP,  8'h44, 8'h31, 1'b0, 1'b0);
    step(1'b1, RET,  8'h00, 8'h31, 1'b0, 1'b0);
    step(1'b1, CALL, 8'h50, 8'h01, 1'b0, 1'b0);
    step(1'b1, CALL, 8'h60, 8'h50, 1'b0, 1'b0);
    step(1'b0, NOP,  8'h00, 8'h60, 1'b0, 1'b0);
    step(1'b1, RET,  8'h00, 8'h60, 1'b0, 1'b0);
    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    step(1'b1, NOP, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
